debounce_sched: RTL and testbench
=================================

// Module: debounce_sched
// PURPOSE
//  Multi-channel debounce controller for NCH raw switch/button inputs.
//  - One shared prescaler generates the sample tick for all channels.
//  - Each channel keeps a small stable-sample counter.
//  - Debounced edges are queued as per-channel pending flags.
//  - A round-robin arbiter emits the queued edges as events on a valid/ready port to the MCS I/O core.
// PARAMETERS
//  NCH         4      number of switch channels (>=2)
//  DIV         50000  clk cycles per sample tick (>=2); 1 ms at 50 MHz
//  STABLE_CNT  20     consecutive disagreeing samples needed to flip a level (>=1)
// PORTS
//  clk         in   1                clock; all logic on rising edge
//  reset_n     in   1                asynchronous, active-low reset
//  en          in   1                1 = run; 0 = freeze prescaler and channel counters
//  sw          in   NCH              raw, asynchronous switch inputs
//  db_level    out  NCH              debounced levels
//  ev_valid    out  1                event available
//  ev_ready    in   1                consumer accepts the event when ev_valid & ev_ready
//  ev_ch       out  $clog2(NCH)      channel index of the event
//  ev_rise     out  1                1 = 0->1 edge, 0 = 1->0 edge
//  ev_overrun  out  1                1-cycle pulse: a new edge replaced a still-pending edge
// BEHAVIOUR
//  Reset:
//   - Asserting reset_n=0 at any time clears all state asynchronously.
//   - db_level=0, ev_valid=0, ev_ch=0, ev_rise=0, ev_overrun=0.
//   - Prescaler=0, all counters=0, pend=0, last_grant=NCH-1 so ch0 wins first.
//   - Nothing from before the reset is emitted after it.
//  Synchroniser:
//   - 2-FF synchroniser per channel (reset 0) produces sync[i].
//  Prescaler:
//   - Counts 0..DIV-1 while en=1, then wraps to 0.
//   - tick=1 for one cycle when count==DIV-1 and en=1.
//   - en=0 holds the count; no ticks.
//  Channel i (all updates on tick only; sync is ignored between ticks):
//   - sync[i]==db_level[i]: cnt[i] <= 0.
//   - sync[i]!=db_level[i] and cnt[i]+1 < STABLE_CNT: cnt[i] <= cnt[i]+1.
//   - sync[i]!=db_level[i] and cnt[i]+1 == STABLE_CNT:
//     db_level[i] <= sync[i], cnt[i] <= 0, pend[i] <= 1, pdir[i] <= sync[i].
//   - Counter width is $clog2(STABLE_CNT+1); the counter never wraps.
//   - A single disagreeing sample followed by an agreeing one restarts the count.
//  Overrun:
//   - A channel edge while pend[i]=1 and not granted that cycle: pdir[i] <= new dir, pend stays 1, ev_overrun=1 next cycle.
//   - Several simultaneous overruns give a single pulse.
//  Arbiter / output register:
//   - Loads when ev_valid=0 or (ev_valid & ev_ready).
//   - Selects the first set pend bit searching last_grant+1, +2, ... (mod NCH).
//   - On a load: ev_valid=1, ev_ch=k, ev_rise=pdir[k], pend[k] cleared, last_grant=k.
//   - No pend bit set on a load opportunity: ev_valid <= 0.
//   - While ev_valid & !ev_ready: ev_ch and ev_rise are held stable and ev_valid stays 1.
//   - With ev_ready tied to 1: one event per cycle, back to back.
//  Grant and new edge on the same channel in the same cycle:
//   - The granted (old) direction is emitted.
//   - pend[k] stays set with the new direction.
//   - No overrun pulse.
//  Latency:
//   - Deciding tick in cycle T: db_level and pend update at T+1.
//   - Earliest ev_valid is T+2, when the output register is free.
//   - The raw-input synchroniser adds 2 cycles ahead of this.
//  en=0:
//   - db_level, cnt and pend are frozen.
//   - The arbiter and handshake keep operating, so pending events drain.
// TESTING (NCH=4, DIV=4, STABLE_CNT=3, ev_ready=1 unless stated)
//  1. sw[0] 0->1 and held -> db_level[0] rises on the 3rd tick after sync (ticks every 4 clk).
//     One event: ev_ch=0, ev_rise=1, ev_valid high for 1 cycle.
//  2. sw[1] high for 2 ticks, then low -> db_level[1] stays 0, no event.
//     Repeat the glitch for 1 tick -> no event.
//  3. sw=4'b1111 in the same cycle -> 4 events on consecutive cycles: ch 0,1,2,3, all with ev_rise=1.
//  4. ev_ready=0; sw[2] up, later down (two edges):
//     - First event held stable.
//     - ev_overrun pulses once.
//     - After ev_ready=1: first event accepted, then ev_ch=2 with ev_rise=0.
//  5. en=0 midway through a count -> no ticks, cnt holds.
//     en=1 -> count resumes from the held value.
//  6. reset_n=0 mid-count with an event pending -> all outputs 0, no event after release.
//     sw=1 held through reset -> rise event after 3 ticks.

Source files
------------

// File: rtl/debounce_sched_if.sv
// Event port between the debounce scheduler and its consumer:
// valid/ready handshake carrying a channel index, edge direction and an overrun pulse.
interface debounce_sched_if #(
    parameter int NCH = 4
);
    localparam int CHW = $clog2(NCH);

    logic           ev_valid;
    logic           ev_ready;
    logic [CHW-1:0] ev_ch;
    logic           ev_rise;
    logic           ev_overrun;

    modport master (
        output ev_valid,
        output ev_ch,
        output ev_rise,
        output ev_overrun,
        input  ev_ready
    );

    modport slave (
        input  ev_valid,
        input  ev_ch,
        input  ev_rise,
        input  ev_overrun,
        output ev_ready
    );
endinterface

// File: rtl/debounce_sched.sv
// Multi-channel switch debouncer: shared sample prescaler, per-channel stable counters,
// pending-edge flags and a round-robin arbiter feeding a valid/ready event port.
module debounce_sched #(
    parameter int NCH        = 4,
    parameter int DIV        = 50000,
    parameter int STABLE_CNT = 20
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              en,
    input  logic [NCH-1:0]    sw,
    output logic [NCH-1:0]    db_level,
    debounce_sched_if.master  ev
);
    localparam int CHW = $clog2(NCH);
    localparam int PW  = $clog2(DIV);
    localparam int CW  = $clog2(STABLE_CNT + 1);

    localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(STABLE_CNT - 1);

    logic [NCH-1:0] sync1_q, sync2_q;
    logic [PW-1:0]  presc_q, presc_d;
    logic [CW-1:0]  cnt_q [NCH];
    logic [CW-1:0]  cnt_d [NCH];
    logic [NCH-1:0] db_q, db_d;
    logic [NCH-1:0] pend_q, pend_d;
    logic [NCH-1:0] pdir_q, pdir_d;
    logic [CHW-1:0] last_grant_q, last_grant_d;
    logic           ev_valid_q, ev_valid_d;
    logic [CHW-1:0] ev_ch_q, ev_ch_d;
    logic           ev_rise_q, ev_rise_d;
    logic           ev_overrun_q, ev_overrun_d;

    logic           tick;
    logic [NCH-1:0] flip;
    logic [NCH-1:0] grant;
    logic           load;
    logic           found;
    logic [CHW-1:0] grant_idx;
    logic [CHW-1:0] cand;

    // NOTE: every variable gets a default at the top of always_comb, so no path can infer a latch.
    always_comb begin
        presc_d      = presc_q;
        tick         = 1'b0;
        cnt_d        = cnt_q;
        db_d         = db_q;
        flip         = '0;
        pend_d       = pend_q;
        pdir_d       = pdir_q;
        last_grant_d = last_grant_q;
        ev_valid_d   = ev_valid_q;
        ev_ch_d      = ev_ch_q;
        ev_rise_d    = ev_rise_q;
        ev_overrun_d = 1'b0;
        grant        = '0;
        found        = 1'b0;
        grant_idx    = '0;
        cand         = '0;

        if (en) begin
            if (presc_q == PRESC_MAX) begin
                presc_d = '0;
                tick    = 1'b1;
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end

        // Between ticks the synchronised input is ignored entirely.
        if (tick) begin
            for (int i = 0; i < NCH; i++) begin
                if (sync2_q[i] == db_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == CNT_LAST) begin
                    cnt_d[i] = '0;
                    db_d[i]  = sync2_q[i];
                    flip[i]  = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end

        // Round-robin search starts just after the last granted channel.
        for (int off = 1; off <= NCH; off++) begin
            cand = CHW'((int'(last_grant_q) + off) % NCH);
            if (!found && pend_q[cand]) begin
                found     = 1'b1;
                grant_idx = cand;
            end
        end

        load = !ev_valid_q || ev.ev_ready;
        if (load) begin
            ev_valid_d = found;
            if (found) begin
                ev_ch_d           = grant_idx;
                ev_rise_d         = pdir_q[grant_idx];
                pend_d[grant_idx] = 1'b0;
                last_grant_d      = grant_idx;
                grant[grant_idx]  = 1'b1;
            end
        end

        // A new edge on a just-granted channel re-arms it without counting as an overrun.
        for (int i = 0; i < NCH; i++) begin
            if (flip[i]) begin
                if (pend_q[i] && !grant[i]) ev_overrun_d = 1'b1;
                pend_d[i] = 1'b1;
                pdir_d[i] = db_d[i];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            presc_q      <= '0;
            db_q         <= '0;
            pend_q       <= '0;
            pdir_q       <= '0;
            last_grant_q <= CHW'(NCH - 1);
            ev_valid_q   <= 1'b0;
            ev_ch_q      <= '0;
            ev_rise_q    <= 1'b0;
            ev_overrun_q <= 1'b0;
            // NOTE: the counter array is reset too; a stale partial count must not survive reset.
            for (int i = 0; i < NCH; i++) cnt_q[i] <= '0;
        end else begin
            sync1_q      <= sw;
            sync2_q      <= sync1_q;
            presc_q      <= presc_d;
            cnt_q        <= cnt_d;
            db_q         <= db_d;
            pend_q       <= pend_d;
            pdir_q       <= pdir_d;
            last_grant_q <= last_grant_d;
            ev_valid_q   <= ev_valid_d;
            ev_ch_q      <= ev_ch_d;
            ev_rise_q    <= ev_rise_d;
            ev_overrun_q <= ev_overrun_d;
        end
    end

    assign db_level      = db_q;
    assign ev.ev_valid   = ev_valid_q;
    assign ev.ev_ch      = ev_ch_q;
    assign ev.ev_rise    = ev_rise_q;
    assign ev.ev_overrun = ev_overrun_q;
endmodule

// File: tb/tb_debounce_sched.sv
// Self-checking bench for debounce_sched (NCH=4, DIV=4, STABLE_CNT=3): vector table plus
// hand-written sequences, with an event scoreboard fed at stimulus time.
module tb_debounce_sched;
    localparam int NCH = 4;

    typedef struct packed {
        logic [3:0]      sw;
        logic [7:0]      hold;
        logic            chk;
        logic [3:0]      db;
        logic [2:0]      n_ev;
        logic [3:0][1:0] chs;
        logic [3:0]      rises;
    } vec_t;

    typedef struct packed {
        logic [1:0] ch;
        logic       rise;
    } ev_t;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic           en = 1'b1;
    logic [NCH-1:0] sw = '0;
    logic [NCH-1:0] db_level;

    debounce_sched_if #(.NCH(NCH)) ev_bus ();

    debounce_sched #(.NCH(NCH), .DIV(4), .STABLE_CNT(3)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .en       (en),
        .sw       (sw),
        .db_level (db_level),
        .ev       (ev_bus)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_err    = 0;
    int   ovr_cnt  = 0;
    ev_t  exp_q[$];
    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] s, input logic [7:0] h, input logic c,
                                input logic [3:0] d, input logic [2:0] n,
                                input logic [7:0] chs, input logic [3:0] r);
        vec_t v;
        v.sw = s; v.hold = h; v.chk = c; v.db = d; v.n_ev = n; v.chs = chs; v.rises = r;
        return v;
    endfunction

    task automatic wait_valid(input int budget, input string name);
        int n = 0;
        while (!ev_bus.ev_valid && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, {31'd0, ev_bus.ev_valid}, 32'd1);
    endtask

    // Scoreboard: every accepted event must match the oldest expected one.
    always begin
        @(negedge clk);
        #1;
        if (ev_bus.ev_valid && ev_bus.ev_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_event", {29'd0, ev_bus.ev_ch, ev_bus.ev_rise}, 32'h7ff);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                check("event", {29'd0, ev_bus.ev_ch, ev_bus.ev_rise}, {29'd0, e.ch, e.rise});
            end
        end
    end

    always @(negedge clk) if (ev_bus.ev_overrun) ovr_cnt++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1);
    end

    initial begin
        int hold_bad;
        int b2b;

        vecs[0]  = mk(4'b0000, 8'd20, 1'b1, 4'b0000, 3'd0, 8'h00, 4'b0000);
        vecs[1]  = mk(4'b0001, 8'd24, 1'b1, 4'b0001, 3'd1, 8'h00, 4'b0001);
        vecs[2]  = mk(4'b0011, 8'd8,  1'b1, 4'b0001, 3'd0, 8'h00, 4'b0000);
        vecs[3]  = mk(4'b0001, 8'd16, 1'b1, 4'b0001, 3'd0, 8'h00, 4'b0000);
        vecs[4]  = mk(4'b0011, 8'd4,  1'b1, 4'b0001, 3'd0, 8'h00, 4'b0000);
        vecs[5]  = mk(4'b0001, 8'd16, 1'b1, 4'b0001, 3'd0, 8'h00, 4'b0000);
        vecs[6]  = mk(4'b0011, 8'd12, 1'b0, 4'b0000, 3'd2, 8'h05, 4'b0001);
        vecs[7]  = mk(4'b0001, 8'd32, 1'b1, 4'b0001, 3'd0, 8'h00, 4'b0000);
        vecs[8]  = mk(4'b0000, 8'd24, 1'b1, 4'b0000, 3'd1, 8'h00, 4'b0000);
        vecs[9]  = mk(4'b1111, 8'd24, 1'b1, 4'b1111, 3'd4, 8'h39, 4'b1111);
        vecs[10] = mk(4'b0000, 8'd24, 1'b1, 4'b0000, 3'd4, 8'h39, 4'b0000);

        ev_bus.ev_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_outputs", {24'd0, db_level, ev_bus.ev_valid, ev_bus.ev_ch, ev_bus.ev_rise,
              ev_bus.ev_overrun}, 32'd0);
        reset_n = 1'b1;

        // Table: levels, glitch rejection at 1/2 ticks, exact-threshold flip, simultaneous edges.
        for (int i = 0; i < 11; i++) begin
            sw = vecs[i].sw;
            for (int j = 0; j < int'(vecs[i].n_ev); j++)
                exp_q.push_back({vecs[i].chs[j], vecs[i].rises[j]});
            repeat (int'(vecs[i].hold)) @(negedge clk);
            if (vecs[i].chk) begin
                check($sformatf("vec%0d_db", i), {28'd0, db_level}, {28'd0, vecs[i].db});
                check($sformatf("vec%0d_drain", i), exp_q.size(), 0);
            end
        end

        // Back-pressure: held event, then a double edge on a pending channel.
        ev_bus.ev_ready = 1'b0;
        ovr_cnt = 0;
        hold_bad = 0;
        exp_q.push_back({2'd3, 1'b1});
        exp_q.push_back({2'd2, 1'b0});
        sw = 4'b1000;
        wait_valid(64, "t4_first_valid");
        sw = 4'b1100;
        repeat (32) begin
            @(negedge clk);
            if (!(ev_bus.ev_valid && ev_bus.ev_ch == 2'd3 && ev_bus.ev_rise)) hold_bad++;
        end
        sw = 4'b1000;
        repeat (32) begin
            @(negedge clk);
            if (!(ev_bus.ev_valid && ev_bus.ev_ch == 2'd3 && ev_bus.ev_rise)) hold_bad++;
        end
        check("t4_hold_stable", hold_bad, 0);
        check("t4_overrun_pulses", ovr_cnt, 1);
        ev_bus.ev_ready = 1'b1;
        repeat (8) @(negedge clk);
        check("t4_drain", exp_q.size(), 0);
        check("t4_db", {28'd0, db_level}, 32'h8);

        // en=0 mid-count: one tick counted, freeze, then exactly two more ticks to flip.
        sw = 4'b1010;
        repeat (6) @(negedge clk);
        en = 1'b0;
        repeat (40) @(negedge clk);
        check("t5_frozen_db", {28'd0, db_level}, 32'h8);
        en = 1'b1;
        exp_q.push_back({2'd1, 1'b1});
        repeat (4) @(negedge clk);
        check("t5_one_more_tick", {28'd0, db_level}, 32'h8);
        repeat (4) @(negedge clk);
        check("t5_resumed_flip", {28'd0, db_level}, 32'ha);
        repeat (6) @(negedge clk);
        check("t5_drain", exp_q.size(), 0);

        // Reset with a held event and a pending edge; input held high through reset.
        ev_bus.ev_ready = 1'b0;
        sw = 4'b1111;
        repeat (32) @(negedge clk);
        check("t6_held_before_reset", {28'd0, ev_bus.ev_valid, ev_bus.ev_ch, ev_bus.ev_rise},
              32'hd);
        #2 reset_n = 1'b0;
        #1;
        check("t6_async_reset", {24'd0, db_level, ev_bus.ev_valid, ev_bus.ev_ch, ev_bus.ev_rise,
              ev_bus.ev_overrun}, 32'd0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        ev_bus.ev_ready = 1'b1;
        for (int c = 0; c < NCH; c++) exp_q.push_back({2'(c), 1'b1});
        wait_valid(64, "t6_first_valid");
        b2b = 0;
        for (int k = 0; k < 4; k++) begin
            if (ev_bus.ev_valid) b2b++;
            @(negedge clk);
        end
        check("t6_back_to_back", b2b, 4);
        check("t6_valid_low_after", {31'd0, ev_bus.ev_valid}, 32'd0);
        repeat (4) @(negedge clk);
        check("t6_drain", exp_q.size(), 0);
        check("t6_db", {28'd0, db_level}, 32'hf);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
